qea_host_ctrl: RTL and testbench
================================

# qea_host_ctrl

Host-side sequencer for the QEA quantum emulation accelerator. It streams gate-context words into the QEA context RAM and writes the |0…0⟩ initial state vector into the state RAM. It then pulses start, waits for completion with a cycle counter and timeout, and streams the final state vector out row by row under valid/ready backpressure. It sits between a host stream interface (DMA/AXI-Stream bridge) and the QEA load/start/readback ports, and replaces bench-driven loading.

## Interface
Parameters:
- PE_NUM, 4, processing elements; one state row = PE_NUM amplitudes
- STATE_DATA_WIDTH, 64, one complex amplitude {re[31:0], im[31:0]}
- STATE_ADDR_WIDTH, 16, state RAM row address width
- GATE_CONTEXT_DATA_WIDTH, 64, context word width
- GATE_CONTEXT_ADDR_WIDTH, 16, context address width
- MAX_QBIT_WIDTH, 6, width of qubit count
- NUM_FRAC_BIT, 30, fixed-point fraction bits; 1.0 = 1<<NUM_FRAC_BIT
- TIMEOUT_WIDTH, 24, completion-wait counter width

Ports (SW = PE_NUM*STATE_DATA_WIDTH):
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_run  in  1  one-cycle request to run a job; ignored unless idle
- i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, sampled on i_run
- i_ins_num  in  GATE_CONTEXT_ADDR_WIDTH  context word count, sampled on i_run
- s_ctx_valid / s_ctx_ready  in / out  1  context stream handshake
- s_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context word
- o_ctx_en, o_ctx_wea  out  1  context RAM write strobe
- o_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH; o_ctx_data  out  GATE_CONTEXT_DATA_WIDTH
- o_state_ena, o_state_wea  out  1  state RAM port A enable / write
- o_state_addra  out  STATE_ADDR_WIDTH; o_state_dina  out  SW
- o_start  out  1  one-cycle start pulse to QEA; o_qbit_num  out  MAX_QBIT_WIDTH  latched qubit count
- i_complete  in  1  QEA completion level
- i_state_dout  in  SW  state RAM read data, valid 1 cycle after a read
- m_out_valid / m_out_ready  out / in  1  result stream handshake; m_out_data  out  SW  one state row
- o_busy, o_done, o_timeout, o_err  out  1  status; done/timeout/err are one-cycle pulses
- o_cycles  out  32  cycles from o_start to i_complete, held until next run

## Operation
- States: IDLE → LOAD_CTX → INIT_STATE → START → WAIT → RD_REQ → RD_CAP → RD_OUT → (RD_REQ | FINISH) → IDLE.
- IDLE, i_run=1: latch qbit_num, ins_num, rows = 2**(qbit_num−2). If qbit_num < 2 or qbit_num−2 > STATE_ADDR_WIDTH, pulse o_err and stay IDLE. Otherwise set o_busy and clear o_cycles.
- LOAD_CTX: s_ctx_ready=1. Each accepted beat drives en=wea=1, addr=beat index from 0, data=s_ctx_data in the same cycle. Leave after ins_num beats. ins_num=0 skips the state. Beats beyond ins_num are not accepted.
- INIT_STATE: writes rows 0..rows−1, one per cycle. Row 0 dina has the top slot [SW−1 -: 32] = 1<<NUM_FRAC_BIT and all other bits 0. All other rows are 0.
- START: o_start=1 for exactly one cycle. WAIT begins on the next cycle.
- WAIT: counter increments each cycle. On i_complete=1: o_cycles = counter, go to RD_REQ with row 0. If the counter reaches all-ones: pulse o_timeout, go to FINISH with no readback.
- RD_REQ: ena=1, wea=0, addra=row. RD_CAP: register i_state_dout into m_out_data. RD_OUT: m_out_valid=1 until m_out_ready. Then go to the next row, or to FINISH after the last row.
- FINISH: pulse o_done (also pulsed after a timeout), drop o_busy, return to IDLE.
- i_run while busy is ignored. i_complete outside WAIT is ignored.

## Timing
- Reset: state IDLE. Every output is 0: all strobes, addresses, data, o_start, status bits, o_cycles, m_out_valid. o_qbit_num resets to 0.
- Reset asserted mid-job aborts immediately. There is no partial drain.
- Context load: 1 word/cycle when s_ctx_valid is held. The RAM write is combinational from the handshake (zero added latency).
- INIT_STATE takes exactly `rows` cycles. START is 1 cycle.
- o_cycles counts from 1 (first WAIT cycle) to the cycle i_complete is sampled.
- Readback: ≥3 cycles per row. m_out_data is stable while m_out_valid=1 and m_out_ready=0.
- i_run to o_start latency = 1 + ins_num (at full rate) + rows cycles.

## Test plan
- qbit=3, ins_num=41, continuous ctx stream, model completes after 500 cycles → 41 ctx writes at addr 0..40. Then 2 state writes: row0 = {64'h40000000_00000000, 0, 0, 0}, row1 = 0. One o_start, o_cycles=500, 2 output rows, o_done.
- Same job with s_ctx_valid toggling 1/0 and m_out_ready low for 7 cycles per row → addresses contiguous, no dropped or duplicated beats, m_out_data held stable.
- TIMEOUT_WIDTH=4, i_complete never set → o_timeout after 15 WAIT cycles, then o_done, no state reads, o_busy=0.
- i_qbit_num=1 → o_err pulse, no RAM strobes, o_busy stays 0. Then ins_num=0, qbit=2 → no ctx writes, 1 state write, normal completion.
- rst_n pulled low during WAIT and again during RD_OUT → all outputs 0 immediately. A subsequent job with i_complete pulsed before start runs correctly.
- i_run pulsed again during LOAD_CTX → ignored, sampled parameters unchanged.

Source files
------------

// File: rtl/qea_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : qea_host_ctrl
// Description : Host-side job sequencer for the QEA accelerator. Streams
//               gate-context words into the context RAM, writes the |0..0>
//               initial state vector, pulses start, times the run against a
//               timeout, then streams the final state vector out row by row.
// Ports       : clk/rst_n            clock, async active-low reset
//               i_run, i_qbit_num,
//               i_ins_num            job request and its parameters
//               s_ctx_*              context word input stream
//               o_ctx_*              context RAM write port
//               o_state_*, i_state_dout  state RAM port A (write + readback)
//               o_start, o_qbit_num, i_complete  QEA control
//               m_out_*              result row output stream
//               o_busy, o_done, o_timeout, o_err, o_cycles  status
// Revision    : 1.0 - initial release
// ============================================================================
module qea_host_ctrl #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int TIMEOUT_WIDTH           = 24
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_run,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 s_ctx_valid,
    output logic                                 s_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 m_out_valid,
    input  logic                                 m_out_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_out_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_timeout,
    output logic                                 o_err,
    output logic [31:0]                          o_cycles
);

    localparam int          c_sw  = PE_NUM * STATE_DATA_WIDTH;
    // Amplitude 1.0 + 0i placed in the real half of the top slot of row 0.
    localparam logic [31:0] c_one = 32'd1 << NUM_FRAC_BIT;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD_CTX   = 4'd1,
        S_INIT_STATE = 4'd2,
        S_START      = 4'd3,
        S_WAIT       = 4'd4,
        S_RD_REQ     = 4'd5,
        S_RD_CAP     = 4'd6,
        S_RD_OUT     = 4'd7,
        S_FINISH     = 4'd8
    } state_t;

    state_t                               state_q,    state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q,     qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q,      ins_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_idx_q,  ctx_idx_d;
    logic [STATE_ADDR_WIDTH-1:0]          last_row_q, last_row_d;
    logic [STATE_ADDR_WIDTH-1:0]          row_q,      row_d;
    logic [TIMEOUT_WIDTH-1:0]             cnt_q,      cnt_d;
    logic [31:0]                          cycles_q,   cycles_d;
    logic [c_sw-1:0]                      out_data_q, out_data_d;

    logic [MAX_QBIT_WIDTH:0]              w_qbit_ext;
    logic                                 w_qbit_ok;
    logic [MAX_QBIT_WIDTH-1:0]            w_shamt;
    logic [STATE_ADDR_WIDTH-1:0]          w_last_row;

    // Row count is 2**(qbit-2); only the last row index is kept, which is
    // the low (qbit-2) bits set. This also covers qbit-2 == address width.
    assign w_qbit_ext = {1'b0, i_qbit_num};
    assign w_qbit_ok  = (w_qbit_ext >= (MAX_QBIT_WIDTH+1)'(2)) &&
                        (w_qbit_ext <= (MAX_QBIT_WIDTH+1)'(STATE_ADDR_WIDTH + 2));
    assign w_shamt    = i_qbit_num - MAX_QBIT_WIDTH'(2);
    assign w_last_row = ~({STATE_ADDR_WIDTH{1'b1}} << w_shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            qbit_q     <= '0;
            ins_q      <= '0;
            ctx_idx_q  <= '0;
            last_row_q <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            cycles_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            qbit_q     <= qbit_d;
            ins_q      <= ins_d;
            ctx_idx_q  <= ctx_idx_d;
            last_row_q <= last_row_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            cycles_q   <= cycles_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        qbit_d        = qbit_q;
        ins_d         = ins_q;
        ctx_idx_d     = ctx_idx_q;
        last_row_d    = last_row_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        cycles_d      = cycles_q;
        out_data_d    = out_data_q;
        s_ctx_ready   = 1'b0;
        o_ctx_en      = 1'b0;
        o_ctx_wea     = 1'b0;
        o_ctx_addr    = '0;
        o_ctx_data    = '0;
        o_state_ena   = 1'b0;
        o_state_wea   = 1'b0;
        o_state_addra = '0;
        o_state_dina  = '0;
        o_start       = 1'b0;
        m_out_valid   = 1'b0;
        o_done        = 1'b0;
        o_timeout     = 1'b0;
        o_err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    if (!w_qbit_ok) begin
                        o_err = 1'b1;
                    end else begin
                        qbit_d     = i_qbit_num;
                        ins_d      = i_ins_num;
                        last_row_d = w_last_row;
                        ctx_idx_d  = '0;
                        row_d      = '0;
                        cycles_d   = '0;
                        state_d    = (i_ins_num == '0) ? S_INIT_STATE : S_LOAD_CTX;
                    end
                end
            end
            S_LOAD_CTX: begin
                // RAM write rides directly on the handshake; ready drops as
                // soon as the last beat is taken because the state changes.
                s_ctx_ready = 1'b1;
                if (s_ctx_valid) begin
                    o_ctx_en   = 1'b1;
                    o_ctx_wea  = 1'b1;
                    o_ctx_addr = ctx_idx_q;
                    o_ctx_data = s_ctx_data;
                    if (ctx_idx_q == ins_q - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
                        state_d = S_INIT_STATE;
                    end else begin
                        ctx_idx_d = ctx_idx_q + GATE_CONTEXT_ADDR_WIDTH'(1);
                    end
                end
            end
            S_INIT_STATE: begin
                o_state_ena   = 1'b1;
                o_state_wea   = 1'b1;
                o_state_addra = row_q;
                if (row_q == '0) begin
                    o_state_dina[c_sw-1 -: 32] = c_one;
                end
                if (row_q == last_row_q) begin
                    row_d   = '0;
                    state_d = S_START;
                end else begin
                    row_d = row_q + STATE_ADDR_WIDTH'(1);
                end
            end
            S_START: begin
                o_start = 1'b1;
                // First WAIT cycle counts as 1.
                cnt_d   = TIMEOUT_WIDTH'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_complete) begin
                    cycles_d = 32'(cnt_q);
                    row_d    = '0;
                    state_d  = S_RD_REQ;
                end else if (&cnt_q) begin
                    o_timeout = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
            end
            S_RD_REQ: begin
                o_state_ena   = 1'b1;
                o_state_addra = row_q;
                state_d       = S_RD_CAP;
            end
            S_RD_CAP: begin
                out_data_d = i_state_dout;
                state_d    = S_RD_OUT;
            end
            S_RD_OUT: begin
                m_out_valid = 1'b1;
                if (m_out_ready) begin
                    if (row_q == last_row_q) begin
                        state_d = S_FINISH;
                    end else begin
                        row_d   = row_q + STATE_ADDR_WIDTH'(1);
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_FINISH: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign o_qbit_num = qbit_q;
    assign o_cycles   = cycles_q;
    assign m_out_data = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_qea_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_qea_host_ctrl
// Description : Self-checking bench for qea_host_ctrl. A table of job records
//               is run through the sequencer with a context source, a QEA
//               completion model, a state RAM read model and a result sink;
//               hand-written sequences cover reset, error and abort cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qea_host_ctrl;

    localparam int SAW = 16;
    localparam int GAW = 16;
    localparam int MQW = 6;
    localparam int TW  = 10;
    localparam int SW  = 256;
    localparam logic [SW-1:0] c_row0 = {32'h4000_0000, 224'h0};

    logic            clk, rst_n, i_run, s_ctx_valid, s_ctx_ready, o_ctx_en, o_ctx_wea;
    logic [MQW-1:0]  i_qbit_num, o_qbit_num;
    logic [GAW-1:0]  i_ins_num, o_ctx_addr;
    logic [63:0]     s_ctx_data, o_ctx_data;
    logic            o_state_ena, o_state_wea, o_start, i_complete;
    logic [SAW-1:0]  o_state_addra;
    logic [SW-1:0]   o_state_dina, i_state_dout, m_out_data;
    logic            m_out_valid, m_out_ready, o_busy, o_done, o_timeout, o_err;
    logic [31:0]     o_cycles;

    qea_host_ctrl #(.TIMEOUT_WIDTH(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_run(i_run), .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num), .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready),
        .s_ctx_data(s_ctx_data), .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
        .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena),
        .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .o_start(o_start), .o_qbit_num(o_qbit_num),
        .i_complete(i_complete), .i_state_dout(i_state_dout),
        .m_out_valid(m_out_valid), .m_out_ready(m_out_ready), .m_out_data(m_out_data),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_err(o_err),
        .o_cycles(o_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ctxpat(input int i);
        logic [31:0] a, b;
        a = 32'(i);
        b = 32'(i * 7);
        return 64'hC0DE_0000_0000_0000 ^ {a, b};
    endfunction

    function automatic logic [SW-1:0] rdpat(input int r);
        logic [31:0] a, b;
        a = 32'hA500_0000 + 32'(r);
        b = 32'h0000_5A00 + 32'(r);
        return {4{a, b}};
    endfunction

    // State RAM read port: data one cycle after an enabled read.
    always @(posedge clk) begin
        if (o_state_ena && !o_state_wea) i_state_dout <= rdpat(int'(o_state_addra));
    end

    // Event counters (written only here) and per-job bases (written only by the main flow).
    int ctx_cnt = 0, st_cnt = 0, rd_cnt = 0, row_cnt = 0;
    int start_cnt = 0, done_cnt = 0, to_cnt = 0, err_cnt = 0;
    int start_cyc = 0, to_cyc = 0;
    int ctx_base = 0, st_base = 0, rd_base = 0, row_base = 0;
    logic            pv = 1'b0, pr = 1'b0;
    logic [SW-1:0]   pd = '0;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (o_ctx_en) begin
                chk("ctx_wea", o_ctx_wea, 1);
                chk("ctx_addr", o_ctx_addr, ctx_cnt - ctx_base);
                chk("ctx_data", o_ctx_data, ctxpat(ctx_cnt - ctx_base));
                ctx_cnt++;
            end
            if (o_state_ena && o_state_wea) begin
                chk("st_addr", o_state_addra, st_cnt - st_base);
                chk("st_dina", o_state_dina, (st_cnt == st_base) ? c_row0 : '0);
                st_cnt++;
            end
            if (o_state_ena && !o_state_wea) begin
                chk("rd_addr", o_state_addra, rd_cnt - rd_base);
                rd_cnt++;
            end
            if (m_out_valid) begin
                if (pv && !pr) chk("out_stable", m_out_data, pd);
                if (m_out_ready) begin
                    chk("out_data", m_out_data, rdpat(row_cnt - row_base));
                    row_cnt++;
                end
            end
            pv = m_out_valid;
            pr = m_out_ready;
            pd = m_out_data;
            if (o_start)   begin start_cnt++; start_cyc = cyc; end
            if (o_done)    done_cnt++;
            if (o_timeout) begin to_cnt++; to_cyc = cyc; end
            if (o_err)     err_cnt++;
        end
    end

    typedef struct {
        int qbit; int ins; int comp; bit gap; int hold; bit rerun; bit precomp;
        int exp_st; int exp_cycles; int exp_rows; bit exp_to; int exp_lat;
    } job_t;

    job_t jobs[6];

    task automatic set_bases();
        ctx_base = ctx_cnt;
        st_base  = st_cnt;
        rd_base  = rd_cnt;
        row_base = row_cnt;
    endtask

    task automatic run_job(input job_t j);
        int run_cyc, start0, done0, to0, t;
        set_bases();
        start0 = start_cnt;
        done0  = done_cnt;
        to0    = to_cnt;
        @(negedge clk);
        i_run = 1'b1; i_qbit_num = MQW'(j.qbit); i_ins_num = GAW'(j.ins);
        run_cyc = cyc;
        @(negedge clk);
        i_run = 1'b0;
        fork
            begin : ctx_src
                int idx, tc;
                bit ph, hs, rerun_done;
                idx = 0; tc = 0; ph = 1'b0; rerun_done = 1'b0;
                while (idx < j.ins && tc < 5000) begin
                    s_ctx_valid = j.gap ? ph : 1'b1;
                    ph = !ph;
                    s_ctx_data = ctxpat(idx);
                    if (j.rerun && idx == 3 && !rerun_done) begin
                        i_run = 1'b1; i_qbit_num = 6'd5; i_ins_num = 16'd3;
                        rerun_done = 1'b1;
                    end
                    #1;
                    hs = s_ctx_valid && s_ctx_ready;
                    @(negedge clk);
                    i_run = 1'b0;
                    if (hs) idx++;
                    tc++;
                end
                s_ctx_valid = 1'b0;
                chk("ctx_beats", idx, j.ins);
            end
            begin : qea_model
                int tq;
                tq = 0;
                if (j.precomp) begin
                    i_complete = 1'b1;
                    @(negedge clk);
                    i_complete = 1'b0;
                end
                while (!o_start && tq < 5000) begin @(negedge clk); tq++; end
                if (j.comp > 0) begin
                    repeat (j.comp) @(negedge clk);
                    i_complete = 1'b1;
                    @(negedge clk);
                    i_complete = 1'b0;
                end
            end
            begin : sink
                int r, ts;
                r = 0; ts = 0;
                while (r < j.exp_rows && ts < 5000) begin
                    if (m_out_valid) begin
                        repeat (j.hold) @(negedge clk);
                        m_out_ready = 1'b1;
                        @(negedge clk);
                        m_out_ready = 1'b0;
                        r++;
                    end else begin
                        @(negedge clk);
                        ts++;
                    end
                end
            end
        join
        t = 0;
        while (done_cnt == done0 && t < 3000) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        chk("ctx_writes", ctx_cnt - ctx_base, j.ins);
        chk("state_writes", st_cnt - st_base, j.exp_st);
        chk("start_pulses", start_cnt - start0, 1);
        chk("state_reads", rd_cnt - rd_base, j.exp_rows);
        chk("out_rows", row_cnt - row_base, j.exp_rows);
        chk("done_pulses", done_cnt - done0, 1);
        chk("timeout_pulses", to_cnt - to0, j.exp_to);
        chk("cycles", o_cycles, j.exp_cycles);
        chk("busy_after", o_busy, 0);
        chk("qbit_latched", o_qbit_num, j.qbit);
        if (j.exp_lat > 0) chk("run_to_start", start_cyc - run_cyc, j.exp_lat);
        if (j.exp_to) chk("wait_to_timeout", to_cyc - start_cyc, (1 << TW) - 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, {o_busy, o_state_ena, o_state_wea, o_ctx_en, o_ctx_wea,
                              s_ctx_ready, m_out_valid, o_start, o_done, o_timeout, o_err}, '0);
        chk({name, "_cycles"}, o_cycles, 0);
        chk({name, "_mdata"}, m_out_data, 0);
        chk({name, "_qbit"}, o_qbit_num, 0);
    endtask

    task automatic wait_start(input string name);
        int t;
        t = 0;
        while (!o_start && t < 2000) begin @(negedge clk); t++; end
        chk(name, o_start, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int e0, s0, c0, t;
        int bad_q[2];
        rst_n = 1'b0; i_run = 1'b0; i_qbit_num = '0; i_ins_num = '0;
        s_ctx_valid = 1'b0; s_ctx_data = ctxpat(5); i_complete = 1'b0;
        m_out_ready = 1'b0; i_state_dout = '0;

        jobs[0] = '{3, 41, 500, 1'b0, 0, 1'b0, 1'b0, 2, 500, 2, 1'b0, 44};
        jobs[1] = '{3, 41, 500, 1'b1, 7, 1'b0, 1'b1, 2, 500, 2, 1'b0, 0};
        jobs[2] = '{2, 0,  20,  1'b0, 0, 1'b0, 1'b1, 1, 20,  1, 1'b0, 2};
        jobs[3] = '{4, 5,  1,   1'b0, 1, 1'b0, 1'b0, 4, 1,   4, 1'b0, 10};
        jobs[4] = '{3, 2,  0,   1'b0, 0, 1'b0, 1'b0, 2, 0,   0, 1'b1, 5};
        jobs[5] = '{3, 10, 30,  1'b1, 2, 1'b1, 1'b0, 2, 30,  2, 1'b0, 0};

        // Reset state, with context data present on the input.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_ctx_bus", {o_ctx_addr, o_ctx_data, o_state_addra}, '0);
        chk("reset_dina", o_state_dina, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Illegal qubit counts: error pulse, nothing else moves.
        bad_q[0] = 1;
        bad_q[1] = 19;
        for (int k = 0; k < 2; k++) begin
            set_bases();
            e0 = err_cnt;
            @(negedge clk);
            i_run = 1'b1; i_qbit_num = MQW'(bad_q[k]); i_ins_num = 16'd4;
            #1;
            chk("err_pulse", o_err, 1);
            @(negedge clk);
            i_run = 1'b0;
            repeat (3) @(negedge clk);
            chk("err_count", err_cnt - e0, 1);
            chk("err_busy", {o_busy, s_ctx_ready}, 0);
            chk("err_strobes", (ctx_cnt - ctx_base) + (st_cnt - st_base) + (rd_cnt - rd_base), 0);
        end

        // Reset during WAIT.
        set_bases();
        @(negedge clk);
        i_run = 1'b1; i_qbit_num = 6'd2; i_ins_num = 16'd0;
        @(negedge clk);
        i_run = 1'b0;
        wait_start("abort1_start");
        repeat (5) @(negedge clk);
        chk("abort1_busy", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort_wait");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during RD_OUT with the sink stalled.
        set_bases();
        @(negedge clk);
        i_run = 1'b1; i_qbit_num = 6'd2; i_ins_num = 16'd0;
        @(negedge clk);
        i_run = 1'b0;
        wait_start("abort2_start");
        @(negedge clk);
        i_complete = 1'b1;
        @(negedge clk);
        i_complete = 1'b0;
        t = 0;
        while (!m_out_valid && t < 50) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk("abort2_valid", m_out_valid, 1);
        chk("abort2_cycles", o_cycles, 1);
        chk("abort2_data", m_out_data, rdpat(0));
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort_rdout");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven jobs.
        for (int i = 0; i < 6; i++) begin
            run_job(jobs[i]);
        end

        // Stray completion while idle must not start anything.
        s0 = start_cnt;
        c0 = o_cycles;
        @(negedge clk);
        i_complete = 1'b1;
        @(negedge clk);
        i_complete = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_complete_ignored", {o_busy, 31'(start_cnt - s0)}, 0);
        chk("idle_cycles_held", o_cycles, c0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
